// File: rtl/sd_pkg.sv
// Shared definitions for the sigma-delta interface: line modes, phase width,
// bit-period arithmetic and the per-mode line level mapping.
package sd_pkg;

  localparam int unsigned SD_PH_W  = 6;
  localparam int unsigned SD_DIV_W = 4;
  localparam int unsigned SD_T_W   = SD_PH_W + 1;

  typedef enum logic [1:0] {
    SD_MODE_CLK   = 2'b00,
    SD_MODE_CLKN  = 2'b01,
    SD_MODE_MANCH = 2'b10,
    SD_MODE_DIV   = 2'b11
  } sd_mode_e;

  typedef struct packed {
    logic dsd;
    logic sdclk;
  } sd_line_t;

  // Bit period in SYSCLK cycles: T = 4*(div+1), range 4..64.
  function automatic logic [SD_T_W-1:0] sd_period(input logic [SD_DIV_W-1:0] div);
    return SD_T_W'((SD_T_W'(div) + SD_T_W'(1)) << 2);
  endfunction

  // Line levels for one half of a bit period.
  function automatic sd_line_t sd_level(input sd_mode_e mode, input logic bit_v,
                                        input logic second);
    sd_line_t lvl;
    lvl.dsd   = bit_v;
    lvl.sdclk = 1'b0;
    case (mode)
      SD_MODE_CLK:   lvl.sdclk = second;
      SD_MODE_CLKN:  lvl.sdclk = ~second;
      SD_MODE_MANCH: lvl.dsd   = second ? bit_v : ~bit_v;
      default:       lvl.dsd   = bit_v;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/sd_ocu_phase.sv
// Bit-period sequencer: phase counter, period/half boundary strobes and the
// shadow mode/divider registers that only change at bit boundaries.
module sd_ocu_phase
  import sd_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          outmode,
  input  logic [SD_DIV_W-1:0] clkdiv,
  output sd_mode_e            mode,
  output logic                period_start_c,
  output logic                half_start_c,
  output logic                stop_c
);

  typedef enum logic {
    PH_IDLE = 1'b0,
    PH_RUN  = 1'b1
  } ph_state_e;

  ph_state_e            state_q, state_d;
  logic [SD_PH_W-1:0]   ph_q, ph_d;
  logic [SD_DIV_W-1:0]  div_q;
  logic [SD_T_W-1:0]    period;
  logic [SD_PH_W-1:0]   last_ph;
  logic [SD_PH_W-1:0]   half_last_ph;

  // Boundary compares use the shadow divider of the period in flight.
  assign period       = sd_period(div_q);
  assign last_ph      = SD_PH_W'(period - SD_T_W'(1));
  assign half_last_ph = SD_PH_W'((period >> 1) - SD_T_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PH_IDLE;
      ph_q    <= '0;
      mode    <= SD_MODE_CLK;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      if (period_start_c) begin
        mode  <= sd_mode_e'(outmode);
        div_q <= clkdiv;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    ph_d           = ph_q;
    period_start_c = 1'b0;
    half_start_c   = 1'b0;
    stop_c         = 1'b0;
    case (state_q)
      PH_IDLE: begin
        ph_d = '0;
        if (en) begin
          state_d        = PH_RUN;
          period_start_c = 1'b1;
        end
      end
      PH_RUN: begin
        if (!en) begin
          state_d = PH_IDLE;
          ph_d    = '0;
          stop_c  = 1'b1;
        end else if (ph_q == last_ph) begin
          ph_d           = '0;
          period_start_c = 1'b1;
        end else begin
          ph_d         = ph_q + SD_PH_W'(1);
          half_start_c = (ph_q == half_last_ph);
        end
      end
      default: begin
        state_d = PH_IDLE;
        ph_d    = '0;
      end
    endcase
  end

endmodule

// File: rtl/sd_ocu.sv
// Sigma-delta output control unit: 1-entry holding buffer, underrun tracking
// and line encoding onto DSDOUT/SDCLKOUT for the four line modes.
module sd_ocu
  import sd_pkg::*;
(
  input  logic                SYSCLK,
  input  logic                SYSRST,
  input  logic                reg_en,
  input  logic [1:0]          reg_outmode,
  input  logic [SD_DIV_W-1:0] reg_clkdiv,
  input  logic                tx_bit,
  input  logic                tx_valid,
  output logic                tx_ready,
  input  logic                underrun_clr,
  output logic                bit_strb,
  output logic                underrun,
  output logic                DSDOUT,
  output logic                SDCLKOUT
);

  sd_mode_e mode_sh;
  logic     period_start_c;
  logic     half_start_c;
  logic     stop_c;
  logic     buf_valid;
  logic     buf_bit;
  logic     cur_bit;
  logic     next_bit_c;
  sd_line_t first_c;
  sd_line_t second_c;

  sd_ocu_phase u_phase (
    .clk            (SYSCLK),
    .rst            (SYSRST),
    .en             (reg_en),
    .outmode        (reg_outmode),
    .clkdiv         (reg_clkdiv),
    .mode           (mode_sh),
    .period_start_c (period_start_c),
    .half_start_c   (half_start_c),
    .stop_c         (stop_c)
  );

  assign tx_ready = !buf_valid;

  // Empty buffer at a period start sends the complement, keeping the stream midscale.
  assign next_bit_c = buf_valid ? buf_bit : ~cur_bit;

  // First-half levels use the mode being latched into the shadow on this edge.
  assign first_c  = sd_level(sd_mode_e'(reg_outmode), next_bit_c, 1'b0);
  assign second_c = sd_level(mode_sh, cur_bit, 1'b1);

  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      buf_valid <= 1'b0;
      buf_bit   <= 1'b0;
      cur_bit   <= 1'b0;
      bit_strb  <= 1'b0;
      underrun  <= 1'b0;
      DSDOUT    <= 1'b0;
      SDCLKOUT  <= 1'b0;
    end else begin
      bit_strb <= period_start_c;

      if (period_start_c) begin
        cur_bit  <= next_bit_c;
        DSDOUT   <= first_c.dsd;
        SDCLKOUT <= first_c.sdclk;
      end else if (half_start_c) begin
        DSDOUT   <= second_c.dsd;
        SDCLKOUT <= second_c.sdclk;
      end else if (stop_c) begin
        DSDOUT   <= 1'b0;
        SDCLKOUT <= 1'b0;
      end

      // No bypass: an accept on a period-start edge only fills the buffer.
      if (period_start_c && buf_valid) begin
        buf_valid <= 1'b0;
      end else if (tx_valid && !buf_valid) begin
        buf_valid <= 1'b1;
        buf_bit   <= tx_bit;
      end

      // A new underrun outranks a simultaneous clear.
      if (period_start_c && !buf_valid) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sd_ocu.sv
// Randomised scoreboard bench for sd_ocu against a period/position reference model.
module tb_sd_ocu;

  logic       SYSCLK;
  logic       SYSRST;
  logic       reg_en;
  logic [1:0] reg_outmode;
  logic [3:0] reg_clkdiv;
  logic       tx_bit;
  logic       tx_valid;
  logic       tx_ready;
  logic       underrun_clr;
  logic       bit_strb;
  logic       underrun;
  logic       DSDOUT;
  logic       SDCLKOUT;

  sd_ocu dut (
    .SYSCLK       (SYSCLK),
    .SYSRST       (SYSRST),
    .reg_en       (reg_en),
    .reg_outmode  (reg_outmode),
    .reg_clkdiv   (reg_clkdiv),
    .tx_bit       (tx_bit),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .underrun_clr (underrun_clr),
    .bit_strb     (bit_strb),
    .underrun     (underrun),
    .DSDOUT       (DSDOUT),
    .SDCLKOUT     (SDCLKOUT)
  );

  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  typedef struct {
    logic d;
    logic c;
    logic s;
    logic u;
    logic r;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state: position inside the current period, its length and mode.
  bit m_run  = 0;
  int m_pos  = 0;
  int m_T    = 4;
  int m_mode = 0;
  bit m_cur  = 0;
  bit m_unr  = 0;
  bit m_strb = 0;
  bit m_buf[$];

  // Expected line levels from the mode definitions, by half of the period.
  task automatic wave(input int mode, input bit b, input bit second,
                      output bit d, output bit c);
    d = b;
    c = 1'b0;
    case (mode)
      0: c = second;
      1: c = !second;
      2: d = second ? b : !b;
      default: ;
    endcase
  endtask

  task automatic model_step();
    exp_t e;
    bit   start;
    bit   uset;
    bit   acc;
    bit   d;
    bit   c;
    start = 0;
    uset  = 0;
    if (SYSRST) begin
      m_run = 0; m_pos = 0; m_T = 4; m_mode = 0;
      m_cur = 0; m_unr = 0; m_strb = 0;
      m_buf.delete();
    end else begin
      acc = tx_valid && (m_buf.size() == 0);
      if (!m_run && reg_en) start = 1;
      else if (m_run && !reg_en) begin
        m_run = 0;
        m_pos = 0;
      end else if (m_run) begin
        if (m_pos == m_T - 1) start = 1;
        else m_pos++;
      end
      if (start) begin
        m_run  = 1;
        m_pos  = 0;
        m_mode = int'(reg_outmode);
        m_T    = 4 * (int'(reg_clkdiv) + 1);
        if (m_buf.size() > 0) m_cur = m_buf.pop_front();
        else begin
          m_cur = !m_cur;
          uset  = 1;
        end
      end
      m_strb = start;
      if (uset) m_unr = 1;
      else if (underrun_clr) m_unr = 0;
      if (acc) m_buf.push_back(tx_bit);
    end
    if (m_run) wave(m_mode, m_cur, m_pos >= m_T / 2, d, c);
    else begin
      d = 0;
      c = 0;
    end
    e.d = d;
    e.c = c;
    e.s = m_strb;
    e.u = m_unr;
    e.r = (m_buf.size() == 0);
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic act, input logic want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, want);
    end
  endtask

  // Monitor: compare one expected sample per cycle, away from the active edge.
  always @(negedge SYSCLK) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("DSDOUT", DSDOUT, e.d);
      check("SDCLKOUT", SDCLKOUT, e.c);
      check("bit_strb", bit_strb, e.s);
      check("underrun", underrun, e.u);
      check("tx_ready", tx_ready, e.r);
    end
  end

  task automatic set_in(input bit rst, input bit en, input int mode, input int div,
                        input bit valid, input bit uclr);
    SYSRST       = rst;
    reg_en       = en;
    reg_outmode  = 2'(mode);
    reg_clkdiv   = 4'(div);
    tx_valid     = valid;
    underrun_clr = uclr;
    tx_bit       = 1'($urandom_range(0, 1));
  endtask

  task automatic tick();
    model_step();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic run(input int n, input bit en, input int mode, input int div,
                     input bit valid);
    for (int i = 0; i < n; i++) begin
      set_in(0, en, mode, div, valid, 0);
      tick();
    end
  endtask

  initial begin
    bit r_en;
    int r_mode;
    int r_div;
    set_in(1, 0, 0, 0, 0, 0);
    tick();
    tick();

    // Mode 00, T=4, buffer kept full.
    run(24, 1, 0, 0, 1);
    // Mode 10, T=8.
    run(24, 1, 2, 1, 1);
    // Mode 01, one bit then starve; clear pulses land on underrun edges.
    run(1, 1, 1, 0, 1);
    for (int i = 0; i < 24; i++) begin
      set_in(0, 1, 1, 0, 0, (i % 4) == 3);
      tick();
    end
    // Divider change mid-period.
    run(6, 1, 0, 0, 1);
    run(40, 1, 0, 3, 1);
    // Disable with a buffered bit, then re-enable.
    run(7, 1, 0, 0, 1);
    run(3, 0, 0, 0, 0);
    run(16, 1, 0, 0, 1);
    // Reset mid-period with the buffer full.
    run(5, 1, 3, 0, 1);
    set_in(1, 1, 3, 0, 1, 0);
    tick();
    run(12, 1, 3, 0, 1);

    // Randomised traffic.
    r_en = 1; r_mode = 0; r_div = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) r_en = !r_en;
      if ($urandom_range(0, 49) == 0) r_mode = $urandom_range(0, 3);
      if ($urandom_range(0, 49) == 0)
        r_div = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      set_in($urandom_range(0, 299) == 0, r_en, r_mode, r_div,
             $urandom_range(0, 99) < 70, $urandom_range(0, 19) == 0);
      tick();
    end

    set_in(0, 0, 0, 0, 0, 0);
    @(negedge SYSCLK);
    #1;
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d samples left unchecked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
